// File: rtl/branch_update_scheduler_if.sv
// Bundle of the scheduler's request, allocation, flush and cache-write signals.
// The master side drives requests; the slave side is the scheduler itself.
interface branch_update_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             ex_req;
  logic [2:0]       ex_idx;
  logic [WIDTH-1:0] ex_data;
  logic             id_req;
  logic [2:0]       id_idx;
  logic [WIDTH-1:0] id_data;
  logic             id_ready;
  logic             flush;
  logic             cache_wen;
  logic [2:0]       cache_dst;
  logic [WIDTH-1:0] cache_data;
  logic             busy;
  logic [1:0]       pend_cnt;

  modport master (
    output enable, ex_req, ex_idx, ex_data, id_req, id_idx, id_data, flush,
    input  id_ready, cache_wen, cache_dst, cache_data, busy, pend_cnt
  );

  modport slave (
    input  enable, ex_req, ex_idx, ex_data, id_req, id_idx, id_data, flush,
    output id_ready, cache_wen, cache_dst, cache_data, busy, pend_cnt
  );
endinterface

// File: rtl/branch_update_scheduler.sv
// Arbitrates execute corrections, decode allocations and flush sweeps onto the
// single branch-cache write port, with a 2-entry pending allocation FIFO.
module branch_update_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  branch_update_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sweep_q, sweep_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [2:0]       fidx_q [2];
  logic [2:0]       fidx_d [2];
  logic [WIDTH-1:0] fdat_q [2];
  logic [WIDTH-1:0] fdat_d [2];
  logic             wen_q, wen_d;
  logic [2:0]       dst_q, dst_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             id_ready;
  logic             id_acc;
  logic             pop;
  logic             keep0;
  logic             keep1;
  logic [1:0]       n;

  assign id_ready = (state_q == IDLE) && (cnt_q != 2'd2);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    fdat_d  = fdat_q;
    wen_d   = 1'b0;
    dst_d   = dst_q;
    data_d  = data_q;
    id_acc  = 1'b0;
    pop     = 1'b0;
    keep0   = 1'b0;
    keep1   = 1'b0;
    n       = 2'd0;
    if (bus.enable) begin
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            cnt_d   = 2'd0;
            sweep_d = 3'd0;
            state_d = SWEEP;
          end else begin
            id_acc = bus.id_req && id_ready;
            if (bus.ex_req) begin
              wen_d  = 1'b1;
              dst_d  = bus.ex_idx;
              data_d = bus.ex_data;
            end else if (cnt_q != 2'd0) begin
              wen_d  = 1'b1;
              dst_d  = fidx_q[0];
              data_d = fdat_q[0];
              pop    = 1'b1;
            end else if (id_acc) begin
              wen_d  = 1'b1;
              dst_d  = bus.id_idx;
              data_d = bus.id_data;
            end
            // A correction to the same entry makes any queued allocation for it stale.
            keep0 = (cnt_q != 2'd0) && !pop && !(bus.ex_req && (fidx_q[0] == bus.ex_idx));
            keep1 = (cnt_q == 2'd2) && !(bus.ex_req && (fidx_q[1] == bus.ex_idx));
            if (keep0) begin
              n = 2'd1;
            end
            if (keep1) begin
              fidx_d[n[0]] = fidx_q[1];
              fdat_d[n[0]] = fdat_q[1];
              n = 2'(n + 2'd1);
            end
            if (id_acc && (bus.ex_req || (cnt_q != 2'd0))) begin
              fidx_d[n[0]] = bus.id_idx;
              fdat_d[n[0]] = bus.id_data;
              n = 2'(n + 2'd1);
            end
            cnt_d = n;
          end
        end
        SWEEP: begin
          wen_d  = 1'b1;
          dst_d  = sweep_q;
          data_d = '0;
          if (sweep_q == 3'd7) begin
            sweep_d = 3'd0;
            state_d = IDLE;
          end else begin
            sweep_d = 3'(sweep_q + 3'd1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sweep_q <= 3'd0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fidx_q[i] <= 3'd0;
        fdat_q[i] <= '0;
      end
      wen_q   <= 1'b0;
      dst_q   <= 3'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      fdat_q  <= fdat_d;
      wen_q   <= wen_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.cache_wen  = wen_q;
  assign bus.cache_dst  = dst_q;
  assign bus.cache_data = data_q;
  assign bus.busy       = (state_q == SWEEP);
  assign bus.pend_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Directed bench: stimulus pushes expected cache writes into a queue and a
// negedge monitor pops and compares each write the scheduler presents.
module tb_branch_update_scheduler;

  typedef struct packed {
    logic [2:0]  dst;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  wr_t  exp_q [$];

  branch_update_scheduler_if #(.WIDTH(16)) bus ();

  branch_update_scheduler #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.cache_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0d/0x%0h required=none",
                 bus.cache_dst, bus.cache_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("cache_write", {13'd0, bus.cache_dst, bus.cache_data}, {13'd0, e.dst, e.data});
      end
    end
  end

  task automatic expw(input logic [2:0] d, input logic [15:0] v);
    wr_t e;
    e.dst  = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic en, input logic ex, input logic [2:0] exi,
                      input logic [15:0] exd, input logic id, input logic [2:0] idi,
                      input logic [15:0] idd, input logic fl);
    bus.enable  = en;
    bus.ex_req  = ex;
    bus.ex_idx  = exi;
    bus.ex_data = exd;
    bus.id_req  = id;
    bus.id_idx  = idi;
    bus.id_data = idd;
    bus.flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.enable = 1'b0; bus.ex_req = 1'b0; bus.ex_idx = 3'd0; bus.ex_data = 16'h0;
    bus.id_req = 1'b0; bus.id_idx = 3'd0; bus.id_data = 16'h0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", bus.cache_wen, 0);
    chk("rst_dst", bus.cache_dst, 0);
    chk("rst_data", bus.cache_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.pend_cnt, 0);
    chk("rst_id_ready", bus.id_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // direct allocation
    expw(3'd3, 16'h1234);
    step(1, 0, 0, 0, 1, 3'd3, 16'h1234, 0);
    chk("direct_pend", bus.pend_cnt, 0);
    idle();

    // correction beats allocation
    expw(3'd1, 16'hAAAA);
    expw(3'd2, 16'h5555);
    step(1, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0);
    chk("prio_pend1", bus.pend_cnt, 1);
    idle();
    chk("prio_pend0", bus.pend_cnt, 0);
    idle();

    // FIFO fills, back-pressure, ordered drain
    expw(3'd0, 16'h1001);
    expw(3'd6, 16'h1002);
    expw(3'd7, 16'h1003);
    expw(3'd4, 16'h2001);
    expw(3'd5, 16'h2002);
    step(1, 1, 3'd0, 16'h1001, 1, 3'd4, 16'h2001, 0);
    chk("fill_pend1", bus.pend_cnt, 1);
    step(1, 1, 3'd6, 16'h1002, 1, 3'd5, 16'h2002, 0);
    chk("fill_pend2", bus.pend_cnt, 2);
    chk("fill_ready0", bus.id_ready, 0);
    step(1, 1, 3'd7, 16'h1003, 1, 3'd4, 16'h2003, 0);
    chk("full_pend2", bus.pend_cnt, 2);
    idle();
    chk("drain_pend1", bus.pend_cnt, 1);
    idle();
    chk("drain_pend0", bus.pend_cnt, 0);
    idle();

    // correction supersedes queued entry
    expw(3'd1, 16'h1111);
    step(1, 1, 3'd1, 16'h1111, 1, 3'd5, 16'h5555, 0);
    chk("drop_setup_pend", bus.pend_cnt, 1);
    expw(3'd5, 16'h0F0F);
    step(1, 1, 3'd5, 16'h0F0F, 0, 0, 0, 0);
    chk("drop_pend", bus.pend_cnt, 0);
    idle();
    idle();

    // same-cycle pop and push; same-idx push beside correction
    expw(3'd2, 16'h2222);
    expw(3'd3, 16'h3333);
    expw(3'd4, 16'h4444);
    step(1, 1, 3'd2, 16'h2222, 1, 3'd3, 16'h3333, 0);
    step(1, 0, 0, 0, 1, 3'd4, 16'h4444, 0);
    chk("poppush_pend", bus.pend_cnt, 1);
    idle();
    chk("poppush_drain", bus.pend_cnt, 0);
    expw(3'd6, 16'h6666);
    expw(3'd6, 16'h6060);
    step(1, 1, 3'd6, 16'h6666, 1, 3'd6, 16'h6060, 0);
    chk("sameidx_pend", bus.pend_cnt, 1);
    idle();
    idle();

    // enable=0 holds everything
    expw(3'd2, 16'h2A2A);
    step(1, 1, 3'd2, 16'h2A2A, 1, 3'd3, 16'h3B3B, 0);
    step(0, 1, 3'd5, 16'h5C5C, 1, 3'd6, 16'h6D6D, 0);
    step(0, 1, 3'd5, 16'h5C5C, 1, 3'd6, 16'h6D6D, 0);
    chk("hold_pend", bus.pend_cnt, 1);
    expw(3'd3, 16'h3B3B);
    idle();
    chk("hold_drain", bus.pend_cnt, 0);
    idle();

    // flush beats FIFO and correction; sweep with a pause
    expw(3'd1, 16'h0101);
    step(1, 1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0);
    step(1, 1, 3'd3, 16'h0303, 1, 3'd4, 16'h0404, 1);
    chk("flush_busy", bus.busy, 1);
    chk("flush_pend", bus.pend_cnt, 0);
    chk("flush_ready", bus.id_ready, 0);
    for (int i = 0; i < 8; i++) begin
      expw(3'(i), 16'h0);
      step(1, (i == 2), 3'd5, 16'hBEEF, 1, 3'd6, 16'hCAFE, (i == 4));
      if (i == 3) begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("pause_busy", bus.busy, 1);
      end
    end
    chk("sweep_done_busy", bus.busy, 0);
    chk("sweep_done_ready", bus.id_ready, 1);
    idle();
    idle();

    // asynchronous reset mid-sweep
    step(1, 0, 0, 0, 0, 0, 0, 1);
    expw(3'd0, 16'h0);
    expw(3'd1, 16'h0);
    idle();
    idle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wen", bus.cache_wen, 0);
    chk("arst_dst", bus.cache_dst, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_pend", bus.pend_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) idle();
    chk("post_rst_busy", bus.busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
